// File: rtl/fifo_rd_serializer.sv
// fifo_rd_serializer: pops wide words from a show-ahead FIFO and emits them
// as RATIO narrow chunks on a valid/ready stream, least-significant chunk
// first, with no bubble between consecutive words.
module fifo_rd_serializer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16,
    parameter int RATIO     = 4,
    parameter int CNT_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_dout,
    output logic                 fifo_rd,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(RATIO - 1);

    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  idx_q, idx_d;
    logic [IN_WIDTH-1:0]  hold_q, hold_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;

    logic                 xfer_s;
    logic                 fifo_rd_s;
    logic [CNT_BITS-1:0]  nxt_idx_s;
    logic [OUT_WIDTH-1:0] nxt_chunk_s;

    // Transfer and pop decode: pop when idle or when the last chunk leaves.
    always_comb begin
        xfer_s = (state_q == SHIFT) & out_ready;
        if (!rst && !fifo_empty && ((state_q == IDLE) || (xfer_s && out_last_q))) begin
            fifo_rd_s = 1'b1;
        end else begin
            fifo_rd_s = 1'b0;
        end
    end

    // Select the chunk that follows the one currently presented.
    always_comb begin
        nxt_idx_s   = idx_q + CNT_BITS'(1);
        nxt_chunk_s = {OUT_WIDTH{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            nxt_chunk_s = (nxt_idx_s == CNT_BITS'(i)) ? hold_q[i*OUT_WIDTH +: OUT_WIDTH] : nxt_chunk_s;
        end
    end

    // Next-state logic: load on pop, advance on non-last transfer, go idle on a final drain.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        case (state_q)
            IDLE: begin
                if (fifo_rd_s) begin
                    state_d    = SHIFT;
                    idx_d      = {CNT_BITS{1'b0}};
                    hold_d     = fifo_dout;
                    out_data_d = fifo_dout[OUT_WIDTH-1:0];
                    out_last_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (fifo_rd_s) begin
                    // Last chunk leaves and the next word arrives in the same cycle.
                    state_d    = SHIFT;
                    idx_d      = {CNT_BITS{1'b0}};
                    hold_d     = fifo_dout;
                    out_data_d = fifo_dout[OUT_WIDTH-1:0];
                    out_last_d = 1'b0;
                end else if (xfer_s && !out_last_q) begin
                    idx_d      = nxt_idx_s;
                    out_data_d = nxt_chunk_s;
                    out_last_d = (nxt_idx_s == LAST_IDX);
                end else if (xfer_s) begin
                    // Final chunk taken with nothing to refill: index stays put, no wrap.
                    state_d    = IDLE;
                    out_last_d = 1'b0;
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d    = IDLE;
                idx_d      = {CNT_BITS{1'b0}};
                out_last_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= {CNT_BITS{1'b0}};
            hold_q     <= {IN_WIDTH{1'b0}};
            out_data_q <= {OUT_WIDTH{1'b0}};
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

    assign fifo_rd   = fifo_rd_s;
    assign out_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Self-checking bench for fifo_rd_serializer: a fixed vector table for the
// reset and single-word timing, then model-checked directed and random runs.
module tb_fifo_rd_serializer;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic [63:0] fifo_dout;
    logic        fifo_rd;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;

    fifo_rd_serializer #(
        .IN_WIDTH (64),
        .OUT_WIDTH(16),
        .RATIO    (4),
        .CNT_BITS (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd   (fifo_rd),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        empty;
        logic        ready;
        logic        chk_data;
        logic        exp_rd;
        logic        exp_valid;
        logic        exp_last;
        logic [15:0] exp_data;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        int          idx;
    } chunk_t;

    int          nvec = 0;
    int          nerr = 0;
    vec_t        tbl[11];
    chunk_t      expq[$];
    logic [63:0] fifoq[$];
    bit          synced    = 1'b0;
    bit          zero_flag = 1'b0;
    bit          gate_empty = 1'b0;
    int          npop, nvalid, first_v, last_v, cyc;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clr_counts();
        npop = 0; nvalid = 0; first_v = -1; last_v = -1; cyc = 0;
    endtask

    // One clock of model-checked operation: inputs from the FIFO model, check at negedge.
    task automatic cycle();
        bit          erd, ev;
        logic [63:0] w;
        fifo_empty = gate_empty || (fifoq.size() == 0);
        fifo_dout  = (fifoq.size() != 0) ? fifoq[0] : {$urandom(), $urandom()};
        @(negedge clk);
        ev  = (expq.size() != 0);
        erd = !rst && !fifo_empty && ((expq.size() == 0) || (out_ready && expq.size() == 1));
        chk("fifo_rd", {63'd0, fifo_rd}, {63'd0, erd});
        if (synced) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
            chk("busy", {63'd0, busy}, {63'd0, ev});
            if (ev) begin
                chk("out_data", {48'd0, out_data}, {48'd0, expq[0].d});
                chk("out_last", {63'd0, out_last}, {63'd0, (expq[0].idx == 3)});
            end else if (zero_flag) begin
                chk("rst_data", {48'd0, out_data}, 64'd0);
                chk("rst_last", {63'd0, out_last}, 64'd0);
            end
        end
        if (fifo_rd) npop++;
        if (out_valid) begin
            nvalid++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        cyc++;
        if (rst) begin
            expq.delete();
            synced    = 1'b1;
            zero_flag = 1'b1;
        end else begin
            if (ev && out_ready) void'(expq.pop_front());
            if (erd) begin
                w = fifoq.pop_front();
                for (int k = 0; k < 4; k++) expq.push_back('{w[k*16 +: 16], k});
                zero_flag = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fifo_empty = 1'b1; fifo_dout = 64'd0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset hold with a non-empty FIFO, then one word drained at full rate.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h2222};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3333};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4444};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111};
        for (int i = 0; i < 11; i++) begin
            rst        = tbl[i].rst;
            fifo_empty = tbl[i].empty;
            out_ready  = tbl[i].ready;
            fifo_dout  = 64'h4444_3333_2222_1111;
            @(negedge clk);
            chk($sformatf("tbl%0d_rd", i), {63'd0, fifo_rd}, {63'd0, tbl[i].exp_rd});
            chk($sformatf("tbl%0d_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].exp_valid});
            if (tbl[i].chk_data) begin
                chk($sformatf("tbl%0d_data", i), {48'd0, out_data}, {48'd0, tbl[i].exp_data});
                chk($sformatf("tbl%0d_last", i), {63'd0, out_last}, {63'd0, tbl[i].exp_last});
            end
            @(posedge clk);
            #1;
        end

        // Streaming: 8 preloaded words must leave as 32 contiguous chunks.
        fifoq.delete();
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) fifoq.push_back({$urandom(), $urandom()});
        clr_counts();
        repeat (40) cycle();
        chk("stream_pops", 64'(npop), 64'd8);
        chk("stream_valid", 64'(nvalid), 64'd32);
        chk("stream_contig", 64'(last_v - first_v + 1), 64'd32);

        // Backpressure: 10-cycle stall on chunk 2 of the first word, then random ready.
        do_reset();
        for (int i = 0; i < 4; i++) fifoq.push_back({$urandom(), $urandom()});
        clr_counts();
        begin
            bit stalled = 1'b0;
            for (int n = 0; n < 100; n++) begin
                if (!stalled && expq.size() == 2 && expq[0].idx == 2) begin
                    out_ready = 1'b0;
                    repeat (10) cycle();
                    stalled = 1'b1;
                end else begin
                    out_ready = ($urandom_range(0, 1) == 1);
                    cycle();
                end
            end
            chk("bp_stalled", {63'd0, stalled}, 64'd1);
        end
        out_ready = 1'b1;
        repeat (20) cycle();
        chk("bp_pops", 64'(npop), 64'd4);
        chk("bp_drained", 64'(expq.size() + fifoq.size()), 64'd0);

        // Empty at the word boundary, then a second word after 5 empty cycles.
        do_reset();
        clr_counts();
        fifoq.push_back(64'hDDDD_CCCC_BBBB_AAAA);
        repeat (6) cycle();
        repeat (5) cycle();
        fifoq.push_back(64'h8888_7777_6666_5555);
        repeat (7) cycle();
        chk("boundary_pops", 64'(npop), 64'd2);

        // Reset after chunk 1 transfers: the rest of the word is dropped.
        do_reset();
        clr_counts();
        fifoq.push_back(64'h0D0D_0C0C_0B0B_0A0A);
        fifoq.push_back(64'h1D1D_1C1C_1B1B_1A1A);
        repeat (3) cycle();
        do_reset();
        repeat (8) cycle();
        chk("rstmid_pops", 64'(npop), 64'd2);
        chk("rstmid_drained", 64'(expq.size() + fifoq.size()), 64'd0);

        // Random traffic: pushes, ready, empty-flag gaps and occasional resets.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 2) == 0 && fifoq.size() < 6) fifoq.push_back({$urandom(), $urandom()});
            out_ready  = ($urandom_range(0, 3) != 0);
            gate_empty = ($urandom_range(0, 7) == 0);
            rst        = ($urandom_range(0, 60) == 0);
            cycle();
        end
        rst = 1'b0;
        gate_empty = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fifo_rd_serializer.md
# fifo_rd_serializer

Reader-side companion to the team's flop-based synchronous FIFOs. It pops IN_WIDTH-bit words from a show-ahead FIFO (data valid whenever not empty, popped by a one-cycle rd), then emits each word as RATIO narrower OUT_WIDTH chunks on a valid/ready stream, least-significant chunk first. It sits between a wide producer-side FIFO and a narrow downstream consumer, and sustains one chunk per cycle with no bubble between words.

## Interface
- IN_WIDTH, 64, FIFO word width.
- OUT_WIDTH, 16, output chunk width; IN_WIDTH must be an integer multiple ≥2 of OUT_WIDTH.
- RATIO, 4, IN_WIDTH/OUT_WIDTH.
- CNT_BITS, 2, chunk index width, ≥ clog2(RATIO).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  IN_WIDTH  FIFO head word; valid when fifo_empty=0.
- fifo_rd  out  1  pop strobe; combinational.
- out_valid  out  1  chunk valid; registered.
- out_data  out  OUT_WIDTH  current chunk; registered.
- out_last  out  1  current chunk is the final chunk (index RATIO-1) of its word.
- out_ready  in  1  consumer accepts the chunk when out_valid & out_ready.
- busy  out  1  a word is held (equals out_valid).

## Operation
- State: IDLE (no word held) and SHIFT (word held in hold_reg, chunk index idx).
- Transfer: xfer = out_valid & out_ready.
- Pop rule: fifo_rd = ~rst & ~fifo_empty & (state==IDLE | (xfer & out_last)). fifo_rd is never asserted while fifo_empty=1.
- On fifo_rd: hold_reg <= fifo_dout, idx <= 0, state <= SHIFT.
- On xfer & ~out_last: idx <= idx+1.
- On xfer & out_last & ~fifo_rd: state <= IDLE.
- out_data = hold_reg[idx*OUT_WIDTH +: OUT_WIDTH], registered together with the index; out_last = (idx==RATIO-1); out_valid = (state==SHIFT).
- out_valid is not deasserted and out_data/out_last do not change while out_valid & ~out_ready (AXI-style stable hold).
- idx does not wrap past RATIO-1; wrap to 0 happens only through a new pop.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, busy=0, fifo_rd=0, idx=0, state=IDLE. hold_reg content is don't-care.
- Reset mid-operation: the held word is discarded and is not re-read; no pop occurs in any cycle where rst=1. The first pop is permitted in the first cycle with rst=0.
- Latency: fifo_empty falls in cycle N while IDLE, so fifo_rd=1 in cycle N and chunk 0 is valid in cycle N+1.
- Throughput: with out_ready held high and the FIFO non-empty, one chunk per cycle. The last chunk of word k is followed directly by chunk 0 of word k+1 in the next cycle.
- Back-to-back boundary: the last chunk transfers while fifo_empty=1, so state goes to IDLE and out_valid=0 in the next cycle. A later non-empty FIFO restarts with 1-cycle latency.
- Simultaneous events: the last-chunk transfer and a pop in the same cycle load the new word, set idx=0, and keep state SHIFT. A non-last transfer never pops.
- RATIO chunks are delivered per popped word, in order idx 0..RATIO-1, with none dropped or duplicated.

## Test plan
- Reset/idle: assert rst for 3 cycles with fifo_empty=0 → fifo_rd=0 throughout; out_valid=0 and out_data=0. The first fifo_rd comes in the cycle after rst falls.
- Single word: fifo_dout=64'h4444_3333_2222_1111, empty falls once, out_ready=1 → 4 consecutive chunks 16'h1111, 2222, 3333, 4444 starting 1 cycle after the pop. out_last=1 only on 16'h4444, then out_valid=0.
- Streaming: 8 words preloaded, out_ready=1 → exactly 8 pops and 32 contiguous valid cycles with no bubble. fifo_rd coincides with each out_last transfer.
- Backpressure: out_ready toggles randomly (including held low for 10 cycles on chunk 2) → out_data/out_last remain stable while stalled. The chunk sequence is identical to the unstalled run, and a pop occurs only on an out_last transfer.
- Empty at boundary: 1 word, then fifo_empty held high for 5 cycles, then a second word → out_valid drops the cycle after the last chunk. The second word's chunk 0 appears 1 cycle after its pop, and no fifo_rd is seen while empty.
- Reset mid-word: assert rst after chunk 1 transfers → outputs return to reset values next cycle. The remaining chunks of that word are never emitted; the next word starts at chunk 0.
